sensor_request_latch: RTL

Front end of the intersection controller's `sensors[4:0]` bus, which the light sequencer consumes.
- Takes the five raw sensor switches and synchronises and debounces each one.
- Turns presses into sticky requests.
- Clears each request when the sequencer's light outputs show that the request has been served.
- Sits between the board switches/GPIO and the sequencer, and closes the loop by reading back `main_lights`/`cross_lights`.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/sensor_debounce.sv | 57 +++++
 rtl/sensor_request_latch.sv | 78 +++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: light codes,
// sensor channel indices and the default sticky/level channel mask.
package traffic_pkg;

  localparam int NUM_SNS = 5;
  localparam int LIGHT_W = 5;

  // One-hot light codes, bit order {red, yellow, green, yellow_arrow, green_arrow}
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 5'b10000;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 5'b01000;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 5'b00100;
  localparam logic [LIGHT_W-1:0] LIGHT_YARROW = 5'b00010;
  localparam logic [LIGHT_W-1:0] LIGHT_GARROW = 5'b00001;

  // Sensor bit positions on raw_in / sensors
  localparam int SNS_LEFT_MAIN  = 0;
  localparam int SNS_LEFT_CROSS = 1;
  localparam int SNS_TRAF_CROSS = 2;
  localparam int SNS_WALK_MAIN  = 3;
  localparam int SNS_WALK_CROSS = 4;

  // 1 = sticky request, 0 = debounced level passed straight through
  localparam logic [NUM_SNS-1:0] LATCH_MASK_DEF = 5'b11011;

  typedef logic [LIGHT_W-1:0] light_t;
  typedef logic [NUM_SNS-1:0] sns_vec_t;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser, stable-count debouncer and a
// registered one-cycle pulse when the accepted level goes 0->1.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the asynchronous switch into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after it has disagreed with db for the full
  // window; any return to agreement restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_db   <= r_s2;
        r_cnt  <= '0;
        r_rise <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;

endmodule

// File: rtl/sensor_request_latch.sv
// Front end for the light sequencer: debounces the five sensor switches,
// latches presses into sticky requests and drops each request once the
// sequencer's lights show it has been served.
module sensor_request_latch
  import traffic_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 CNT_W           = 20,
  parameter logic [NUM_SNS-1:0] LATCH_MASK      = LATCH_MASK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SNS-1:0] raw_in,
  input  logic [LIGHT_W-1:0] main_lights,
  input  logic [LIGHT_W-1:0] cross_lights,
  output logic [NUM_SNS-1:0] sensors,
  output logic               any_req
);

  sns_vec_t w_db;
  sns_vec_t w_rise;
  sns_vec_t w_serve;
  sns_vec_t w_sens_nxt;
  sns_vec_t r_sens;
  logic     r_any;

  for (genvar g = 0; g < NUM_SNS; g++) begin : g_ch
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (raw_in[g]),
      .o_db   (w_db[g]),
      .o_rise (w_rise[g])
    );
  end

  // Exact-code serve decode; any other or illegal light code serves nothing
  always_comb begin
    w_serve                 = '0;
    w_serve[SNS_LEFT_MAIN]  = (main_lights  == LIGHT_GARROW);
    w_serve[SNS_LEFT_CROSS] = (cross_lights == LIGHT_GARROW);
    w_serve[SNS_TRAF_CROSS] = (cross_lights == LIGHT_GREEN);
    w_serve[SNS_WALK_MAIN]  = (main_lights  == LIGHT_GREEN);
    w_serve[SNS_WALK_CROSS] = (cross_lights == LIGHT_GREEN);
  end

  // Next request vector: sticky channels set on rise with clear winning,
  // level channels simply follow the debounced level
  always_comb begin
    w_sens_nxt = r_sens;
    for (int i = 0; i < NUM_SNS; i++) begin
      if (LATCH_MASK[i]) begin
        if (w_serve[i])     w_sens_nxt[i] = 1'b0;
        else if (w_rise[i]) w_sens_nxt[i] = 1'b1;
      end else begin
        w_sens_nxt[i] = w_db[i];
      end
    end
  end

  // Register requests and their OR together so any_req never lags sensors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sens <= '0;
      r_any  <= 1'b0;
    end else begin
      r_sens <= w_sens_nxt;
      r_any  <= |w_sens_nxt;
    end
  end

  assign sensors = r_sens;
  assign any_req = r_any;

endmodule
